// File: rtl/tea_block_packer.sv
// tea_block_packer
// Input stage for a combinational 32-round TEA encryptor.
// It holds the 128-bit key and packs an 8-bit byte stream into 64-bit big-endian blocks.
// Each block is presented to the encryptor and held for SETTLE_CYCLES edges.
// The encryptor output is then registered and offered downstream.
// Only one block is in flight at a time.
//
// Optional feature: define TEA_PACKER_BLKCNT_EN to add the blk_count output.
// blk_count is a 16-bit wrapping count of completed output handshakes.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   key_in/key_load/key_ok   key register load and "key present" flag
//   s_data/s_valid/s_ready   byte input stream
//   blk_to_enc/key_to_enc    registered block/key driving the encryptor
//   blk_from_enc             encryptor result
//   m_data/m_valid/m_ready   64-bit output stream
//   busy                     high while a block is settling or held
//   blk_count                (optional) output handshake counter
module tea_block_packer #(
    parameter int SETTLE_CYCLES = 4   // legal range 1..255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_ok,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [63:0]  blk_to_enc,
    output logic [127:0] key_to_enc,
    input  logic [63:0]  blk_from_enc,
    output logic [63:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         busy
`ifdef TEA_PACKER_BLKCNT_EN
    ,
    output logic [15:0]  blk_count
`endif
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    settle_cnt_q, settle_cnt_d;
    logic [63:0]   blk_q, blk_d;
    logic [127:0]  key_q, key_d;
    logic [63:0]   m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          key_ok_q, key_ok_d;
    logic          accept;
    logic          handshake;
`ifdef TEA_PACKER_BLKCNT_EN
    logic [15:0]   blk_count_q, blk_count_d;
`endif

    // s_ready depends on registered state only, never on s_valid.
    assign s_ready    = key_ok_q && (state_q == FILL);
    assign accept     = s_valid && s_ready;
    assign handshake  = m_valid_q && m_ready;
    assign busy       = (state_q == SETTLE) || (state_q == HOLD);
    assign key_ok     = key_ok_q;
    assign blk_to_enc = blk_q;
    assign key_to_enc = key_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
`ifdef TEA_PACKER_BLKCNT_EN
    assign blk_count  = blk_count_q;
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        blk_d        = blk_q;
        key_d        = key_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        key_ok_d     = key_ok_q;
`ifdef TEA_PACKER_BLKCNT_EN
        blk_count_d  = blk_count_q;
`endif
        case (state_q)
            FILL: begin
                if (key_load) begin
                    key_d    = key_in;
                    key_ok_d = 1'b1;
                end
                if (accept) begin
                    // Byte k lands at [63-8k -: 8].
                    // 63-8k equals {~k, 3'b111} for a 3-bit k, so no subtractor is needed.
                    blk_d[{~byte_cnt_q, 3'b111} -: 8] = s_data;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        state_d      = SETTLE;
                        settle_cnt_d = 8'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                // The key is frozen here, so key_load is deliberately ignored.
                if (settle_cnt_q == 8'd0) begin
                    m_data_d  = blk_from_enc;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (key_load) begin
                    key_d    = key_in;
                    key_ok_d = 1'b1;
                end
                if (handshake) begin
                    m_valid_d = 1'b0;
                    state_d   = FILL;
`ifdef TEA_PACKER_BLKCNT_EN
                    blk_count_d = blk_count_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            byte_cnt_q   <= 3'd0;
            settle_cnt_q <= 8'd0;
            blk_q        <= 64'd0;
            key_q        <= 128'd0;
            m_data_q     <= 64'd0;
            m_valid_q    <= 1'b0;
            key_ok_q     <= 1'b0;
`ifdef TEA_PACKER_BLKCNT_EN
            blk_count_q  <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            blk_q        <= blk_d;
            key_q        <= key_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            key_ok_q     <= key_ok_d;
`ifdef TEA_PACKER_BLKCNT_EN
            blk_count_q  <= blk_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_tea_block_packer.sv
// Testbench for tea_block_packer.
// A behavioural TEA model, or a simple inverting stub, drives blk_from_enc.
// Expected blocks are built from byte lists by concatenation.
module tb_tea_block_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         key_ok;
    logic [7:0]   s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [63:0]  blk_to_enc;
    logic [127:0] key_to_enc;
    logic [63:0]  blk_from_enc;
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         busy;
`ifdef TEA_PACKER_BLKCNT_EN
    logic [15:0]  blk_count;
`endif

    int checks = 0;
    int errors = 0;
    logic use_tea = 1'b0;

    always #5 clk = ~clk;

    // Reference TEA.
    // v0 is the low word and v1 the high word; the output is {v1, v0}.
    function automatic logic [63:0] tea_enc(input logic [63:0] blk, input logic [127:0] k);
        logic [31:0] v0, v1, sum;
        v0 = blk[31:0];
        v1 = blk[63:32];
        sum = 32'd0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + sum) ^ ((v1 >> 5) + k[63:32]));
            v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + sum) ^ ((v0 >> 5) + k[127:96]));
        end
        return {v1, v0};
    endfunction

    assign blk_from_enc = use_tea ? tea_enc(blk_to_enc, key_to_enc) : ~blk_to_enc;

    tea_block_packer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_ok(key_ok),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .blk_to_enc(blk_to_enc), .key_to_enc(key_to_enc), .blk_from_enc(blk_from_enc),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
`ifdef TEA_PACKER_BLKCNT_EN
        , .blk_count(blk_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Presents one byte and returns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_data = b;
        s_valid = 1'b1;
        while (!s_ready && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_byte_timeout s_ready=%0b required=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output int n);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!m_valid) begin
            errors++;
            $display("FAIL wait_mvalid_timeout m_valid=%0b required=1", m_valid);
        end
    endtask

    task automatic take();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL take m_valid=%0b busy=%0b s_ready=%0b required 0 0 1", m_valid, busy, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (key_ok !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 ||
            blk_to_enc !== 64'd0 || key_to_enc !== 128'd0 || m_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state key_ok=%0b s_ready=%0b m_valid=%0b busy=%0b blk=%h m_data=%h required all zero",
                     key_ok, s_ready, m_valid, busy, blk_to_enc, m_data);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_before_key();
        s_data = 8'h11;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_ready !== 1'b0 || blk_to_enc !== 64'd0 || key_ok !== 1'b0) begin
                errors++;
                $display("FAIL before_key cyc=%0d s_ready=%0b blk=%h key_ok=%0b required 0 0 0",
                         i, s_ready, blk_to_enc, key_ok);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_packing();
        logic [127:0] k = 128'h0123456789ABCDEF_FEDCBA9876543210;
        logic [63:0] exp_blk = '0;
        load_key(k);
        checks++;
        if (key_ok !== 1'b1 || key_to_enc !== k) begin
            errors++;
            $display("FAIL key_load key_ok=%0b key=%h required 1 %h", key_ok, key_to_enc, k);
        end
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
            exp_blk = {exp_blk[55:0], 8'(i)};
        end
        checks++;
        if (blk_to_enc !== 64'h0102030405060708 || busy !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL packing blk=%h busy=%0b m_valid=%0b required %h 1 0",
                     blk_to_enc, busy, m_valid, exp_blk);
        end
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (m_valid !== (e == 4)) begin
                errors++;
                $display("FAIL latency edge=%0d m_valid=%0b required %0b", e, m_valid, (e == 4));
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (m_data !== 64'hFEFDFCFBFAF9F8F7 || busy !== 1'b1 || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL packing_result m_data=%h busy=%0b m_valid=%0b required %h 1 1",
                         m_data, busy, m_valid, ~exp_blk);
            end
            tick();
        end
        take();
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_blk = '0;
        logic [63:0] held;
        int n;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h20 + i));
            exp_blk = {exp_blk[55:0], 8'(8'h20 + i)};
        end
        wait_mvalid(n);
        held = m_data;
        checks++;
        if (held !== ~exp_blk) begin
            errors++;
            $display("FAIL bp_data m_data=%h required %h", held, ~exp_blk);
        end
        s_data = 8'hAA;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (m_data !== held || m_valid !== 1'b1 || s_ready !== 1'b0 || blk_to_enc !== exp_blk) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d m_data=%h m_valid=%0b s_ready=%0b required %h 1 0",
                         i, m_data, m_valid, s_ready, held);
            end
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release s_ready=%0b m_valid=%0b required 1 0", s_ready, m_valid);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (blk_to_enc[63:56] !== 8'hAA || blk_to_enc[55:0] !== exp_blk[55:0]) begin
            errors++;
            $display("FAIL bp_byte0 blk=%h required %h", blk_to_enc, {8'hAA, exp_blk[55:0]});
        end
        for (int i = 1; i < 8; i++) send_byte(8'(i));
        wait_mvalid(n);
        take();
    endtask

    task automatic test_key_settle();
        logic [127:0] old_key = key_to_enc;
        logic [63:0] held;
        int n;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i));
        tick();
        key_in = '1;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        checks++;
        if (key_to_enc !== old_key) begin
            errors++;
            $display("FAIL key_settle key=%h required %h", key_to_enc, old_key);
        end
        wait_mvalid(n);
        held = m_data;
        load_key('1);
        checks++;
        if (key_to_enc !== '1 || m_data !== held || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL key_hold key=%h m_data=%h required all-ones %h", key_to_enc, m_data, held);
        end
        take();
    endtask

    task automatic test_integration();
        int n;
        use_tea = 1'b1;
        load_key(128'd0);
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        wait_mvalid(n);
        checks++;
        if (m_data !== 64'h94BAA940_41EA3A0A) begin
            errors++;
            $display("FAIL tea_zero m_data=%h required %h", m_data, 64'h94BAA940_41EA3A0A);
        end
        take();
    endtask

    task automatic test_random();
        logic [127:0] exp_key = key_to_enc;
        for (int b = 0; b < 6; b++) begin
            logic [63:0] exp_blk = '0;
            int kpos = $urandom_range(0, 10);
            logic [127:0] nk = {$urandom, $urandom, $urandom, $urandom};
            int n;
            for (int j = 0; j < 8; j++) begin
                logic [7:0] byt = 8'($urandom);
                repeat ($urandom_range(0, 2)) tick();
                // Key load on the same edge as a byte accept.
                if (j == kpos) begin
                    key_in = nk;
                    key_load = 1'b1;
                    exp_key = nk;
                end
                send_byte(byt);
                key_load = 1'b0;
                exp_blk = {exp_blk[55:0], byt};
            end
            wait_mvalid(n);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL rnd_latency blk=%0d edges=%0d required 4", b, n);
            end
            checks++;
            if (m_data !== tea_enc(exp_blk, exp_key) || key_to_enc !== exp_key || blk_to_enc !== exp_blk) begin
                errors++;
                $display("FAIL rnd_result blk=%0d m_data=%h required %h", b, m_data, tea_enc(exp_blk, exp_key));
            end
            repeat ($urandom_range(0, 3)) tick();
            take();
        end
        use_tea = 1'b0;
    endtask

    task automatic test_reset_midblock();
        int n;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i));
        #2 rst = 1'b1;
        #1;
        checks++;
        if (key_ok !== 1'b0 || s_ready !== 1'b0 || blk_to_enc !== 64'd0 || key_to_enc !== 128'd0 ||
            m_valid !== 1'b0 || busy !== 1'b0
`ifdef TEA_PACKER_BLKCNT_EN
            || blk_count !== 16'd0
`endif
            ) begin
            errors++;
            $display("FAIL async_reset key_ok=%0b s_ready=%0b blk=%h busy=%0b required all zero",
                     key_ok, s_ready, blk_to_enc, busy);
        end
        tick();
        rst = 1'b0;
        load_key(128'h5);
        for (int b = 0; b < 2; b++) begin
            logic [63:0] exp_blk = '0;
            for (int i = 0; i < 8; i++) begin
                send_byte(8'(8'h70 + 8 * b + i));
                exp_blk = {exp_blk[55:0], 8'(8'h70 + 8 * b + i)};
            end
            wait_mvalid(n);
            checks++;
            if (m_data !== ~exp_blk) begin
                errors++;
                $display("FAIL post_reset_blk blk=%0d m_data=%h required %h", b, m_data, ~exp_blk);
            end
            take();
        end
`ifdef TEA_PACKER_BLKCNT_EN
        checks++;
        if (blk_count !== 16'd2) begin
            errors++;
            $display("FAIL blk_count got=%0d required 2", blk_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_before_key();
        test_packing();
        test_backpressure();
        test_key_settle();
        test_integration();
        test_random();
        test_reset_midblock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
